// File: rtl/scoreboard_ring.sv
// In-order-commit instruction scoreboard kept in a circular buffer.
// Entries issue out of order once their operands are hazard-free; they retire strictly from the head.
module scoreboard_ring #(
  parameter int DEPTH        = 32,
  parameter int TAG_W        = 32,
  parameter int REG_W        = 5,
  parameter int CHECK_WAW    = 1,
  parameter int RD_ZERO_FREE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic [REG_W-1:0]         push_rd,
  input  logic [REG_W-1:0]         push_rs1,
  input  logic [REG_W-1:0]         push_rs2,
  output logic                     issue_valid,
  output logic [TAG_W-1:0]         issue_tag,
  input  logic                     issue_ack,
  input  logic                     finish_valid,
  input  logic [TAG_W-1:0]         finish_tag,
  output logic                     commit_valid,
  output logic [TAG_W-1:0]         commit_tag,
  input  logic                     commit_ack,
  input  logic                     flush_valid,
  input  logic [TAG_W-1:0]         flush_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FREE, WAIT, RUNNING, DONE} entry_state_e;

  entry_state_e   state_q [DEPTH];
  entry_state_e   state_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [REG_W-1:0] rd_q  [DEPTH];
  logic [REG_W-1:0] rs1_q [DEPTH];
  logic [REG_W-1:0] rs2_q [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [PW-1:0]    ageSlot [DEPTH];
  logic [DEPTH-1:0] readyAge;
  logic [PW-1:0]    issueSlot, finishSlot, flushSlot;
  logic [CW-1:0]    flushAge;
  logic             finishHit, flushHit, commitFire, pushFire;

  function automatic logic regMatch(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && !((RD_ZERO_FREE != 0) && (a == '0));
  endfunction

  // Index 0 of every age-ordered view is the oldest entry (the head).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ageSlot[k] = head_q + PW'(k);
    end
  end

  always_comb begin
    readyAge = '0;
    for (int k = 0; k < DEPTH; k++) begin
      readyAge[k] = (state_q[ageSlot[k]] == WAIT);
      for (int j = 0; j < DEPTH; j++) begin
        if (j < k && (state_q[ageSlot[j]] == WAIT || state_q[ageSlot[j]] == RUNNING)) begin
          if (regMatch(rd_q[ageSlot[j]], rs1_q[ageSlot[k]]) ||
              regMatch(rd_q[ageSlot[j]], rs2_q[ageSlot[k]]) ||
              ((CHECK_WAW != 0) && regMatch(rd_q[ageSlot[j]], rd_q[ageSlot[k]]))) begin
            readyAge[k] = 1'b0;
          end
        end
      end
    end
  end

  // Oldest-first searches for the issue candidate, finish target and flush point.
  always_comb begin
    issue_valid = 1'b0;
    issueSlot   = '0;
    finishHit   = 1'b0;
    finishSlot  = '0;
    flushHit    = 1'b0;
    flushSlot   = '0;
    flushAge    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!issue_valid && readyAge[k]) begin
        issue_valid = 1'b1;
        issueSlot   = ageSlot[k];
      end
      if (!finishHit && finish_valid && state_q[ageSlot[k]] == RUNNING &&
          tag_q[ageSlot[k]] == finish_tag) begin
        finishHit  = 1'b1;
        finishSlot = ageSlot[k];
      end
      if (!flushHit && flush_valid && state_q[ageSlot[k]] != FREE &&
          tag_q[ageSlot[k]] == flush_tag) begin
        flushHit  = 1'b1;
        flushSlot = ageSlot[k];
        flushAge  = CW'(k);
      end
    end
  end

  assign issue_tag    = issue_valid ? tag_q[issueSlot] : '0;
  assign commit_valid = (state_q[head_q] == DONE);
  assign commit_tag   = commit_valid ? tag_q[head_q] : '0;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign push_ready   = !full;
  assign count        = count_q;

  assign commitFire = commit_valid && commit_ack && !(flushHit && flushAge == '0);
  assign pushFire   = push_valid && push_ready && !flushHit;

  // Flush is applied last so it overrides any issue, finish or push aimed at a flushed slot.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(pushFire) - CW'(commitFire);
    if (issue_valid && issue_ack) state_d[issueSlot] = RUNNING;
    if (finishHit) state_d[finishSlot] = DONE;
    if (commitFire) begin
      state_d[head_q] = FREE;
      head_d          = head_q + PW'(1);
    end
    if (pushFire) begin
      state_d[tail_q] = WAIT;
      tail_d          = tail_q + PW'(1);
    end
    if (flushHit) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) >= flushAge) state_d[ageSlot[k]] = FREE;
      end
      tail_d  = flushSlot;
      count_d = flushAge - CW'(commitFire);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) state_q[k] <= FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload fields need no reset; an entry's state alone says whether they are meaningful.
  always_ff @(posedge clock) begin
    if (pushFire) begin
      tag_q[tail_q] <= push_tag;
      rd_q[tail_q]  <= push_rd;
      rs1_q[tail_q] <= push_rs1;
      rs2_q[tail_q] <= push_rs2;
    end
  end

endmodule
